// File: rtl/nabp_image_ram_writer_pkg.sv
// Shared types and default sizes for the NABP image RAM writer.
package nabp_image_writer_pkg;

   localparam int unsigned DEF_ADDR_LEN   = 16;  // kImageAddressLength
   localparam int unsigned DEF_DATA_LEN   = 8;   // kCacheDataLength
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } writer_state_e;

   // One buffered pixel at the default widths.
   typedef struct packed {
      logic [DEF_ADDR_LEN-1:0] addr;
      logic [DEF_DATA_LEN-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/nabp_image_ram_writer_if.sv
// Pixel stream, RAM write port and host status of the image RAM writer.
interface nabp_image_ram_writer_if
   import nabp_image_writer_pkg::*;
#(
   parameter int unsigned ADDR_LEN = DEF_ADDR_LEN,
   parameter int unsigned DATA_LEN = DEF_DATA_LEN
);
   logic                pe_kick;
   logic                pe_done;
   logic                pe_addr_valid;
   logic [ADDR_LEN-1:0] pe_addr;
   logic [DATA_LEN-1:0] pe_val;
   logic                pe_enable;
   logic                mem_wr_en;
   logic [ADDR_LEN-1:0] mem_wr_addr;
   logic [DATA_LEN-1:0] mem_wr_data;
   logic                mem_wr_ready;
   logic                hs_busy;
   logic                hs_done;
   logic [ADDR_LEN:0]   hs_count;
   logic                hs_error;

   // Environment side: NABP producer, RAM and host.
   modport master (
      output pe_kick, pe_done, pe_addr_valid, pe_addr, pe_val, mem_wr_ready,
      input  pe_enable, mem_wr_en, mem_wr_addr, mem_wr_data,
             hs_busy, hs_done, hs_count, hs_error
   );

   // Writer side.
   modport slave (
      input  pe_kick, pe_done, pe_addr_valid, pe_addr, pe_val, mem_wr_ready,
      output pe_enable, mem_wr_en, mem_wr_addr, mem_wr_data,
             hs_busy, hs_done, hs_count, hs_error
   );
endinterface

// File: rtl/nabp_image_ram_writer_fifo.sv
// Small synchronous FIFO; occupancy counter distinguishes full from empty.
module nabp_sync_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 4   // power of two, at least 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == CW'(0));
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointer and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      // NOTE: defaults first so every path assigns every output, no latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking updates so all flops sample the same pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; an empty FIFO makes its contents irrelevant.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/nabp_image_ram_writer.sv
// Buffers the NABP reconstructed-pixel stream and writes it to the image RAM.
module nabp_image_ram_writer
   import nabp_image_writer_pkg::*;
#(
   parameter int unsigned ADDR_LEN   = DEF_ADDR_LEN,
   parameter int unsigned DATA_LEN   = DEF_DATA_LEN,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input logic                   clk,
   input logic                   reset,
   nabp_image_ram_writer_if.slave bus
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_LEN-1:0] addr;
      logic [DATA_LEN-1:0] data;
   } entry_t;

   writer_state_e     state_q, state_d;
   logic [ADDR_LEN:0] count_q, count_d;
   logic              error_q, error_d;

   entry_t            push_entry, head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   logic              pe_enable, accept, pop, empty_next;

   // Enable is a function of registered state only.
   assign pe_enable  = (state_q == RUN) && !fifo_full;
   assign accept     = bus.pe_addr_valid && pe_enable;
   assign pop        = !fifo_empty && bus.mem_wr_ready;
   assign push_entry = '{addr: bus.pe_addr, data: bus.pe_val};
   // FIFO will hold nothing after this edge.
   assign empty_next = !accept && ((fifo_count == CW'(0)) ||
                                   ((fifo_count == CW'(1)) && pop));

   nabp_sync_fifo #(
      .WIDTH (ADDR_LEN + DATA_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Frame FSM, beat counter and sticky protocol-error flag.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      error_d = error_q;
      if (bus.pe_addr_valid && !pe_enable && state_q != RUN) error_d = 1'b1;
      if (bus.pe_kick && state_q != IDLE)                    error_d = 1'b1;
      if (bus.pe_done && state_q != RUN)                     error_d = 1'b1;
      if (accept && count_q != '1) count_d = count_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            if (bus.pe_kick) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         // An already-drained FIFO skips DRAIN so hs_done follows pe_done by one cycle.
         RUN:     if (bus.pe_done) state_d = empty_next ? DONE : DRAIN;
         DRAIN:   if (empty_next)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   assign bus.pe_enable   = pe_enable;
   assign bus.mem_wr_en   = !fifo_empty;
   assign bus.mem_wr_addr = fifo_empty ? '0 : head.addr;
   assign bus.mem_wr_data = fifo_empty ? '0 : head.data;
   assign bus.hs_busy     = (state_q != IDLE);
   assign bus.hs_done     = (state_q == DONE);
   assign bus.hs_count    = count_q;
   assign bus.hs_error    = error_q;

endmodule

// File: tb/tb_nabp_image_ram_writer.sv
// Directed bench for the NABP image RAM writer.
module tb_nabp_image_ram_writer;
   import nabp_image_writer_pkg::*;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   done_cnt = 0;
   fifo_entry_t wr_log[$];

   nabp_image_ram_writer_if bus ();

   nabp_image_ram_writer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mid-cycle monitor: log handshakes, count hs_done, check stall stability.
   logic        stall_prev = 1'b0;
   logic [15:0] addr_prev;
   logic [7:0]  data_prev;
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (bus.mem_wr_en && bus.mem_wr_ready)
            wr_log.push_back('{addr: bus.mem_wr_addr, data: bus.mem_wr_data});
         if (bus.hs_done) done_cnt++;
         if (stall_prev && bus.mem_wr_en) begin
            total++;
            if (bus.mem_wr_addr !== addr_prev || bus.mem_wr_data !== data_prev) begin
               bad++;
               $display("FAIL stall_hold: got %h/%h want %h/%h",
                        bus.mem_wr_addr, bus.mem_wr_data, addr_prev, data_prev);
            end
         end
         stall_prev = bus.mem_wr_en && !bus.mem_wr_ready;
         addr_prev  = bus.mem_wr_addr;
         data_prev  = bus.mem_wr_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick();
      bus.pe_kick = 1'b1;
      tick();
      bus.pe_kick = 1'b0;
   endtask

   // Present n beats at first.. with value = low byte of address; optional done on last.
   task automatic send_beats(input int first, input int n, input bit done_last);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         bus.pe_addr_valid = 1'b1;
         bus.pe_addr       = 16'(first + i);
         bus.pe_val        = 8'(first + i);
         while (bus.pe_enable !== 1'b1 && guard < 200) begin
            tick();
            guard++;
         end
         if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got pe_enable=%b want 1", bus.pe_enable);
         end
         if (done_last && i == n - 1) bus.pe_done = 1'b1;
         tick();
         bus.pe_done = 1'b0;
      end
      bus.pe_addr_valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (bus.hs_done !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      total++;
      if (bus.hs_done !== 1'b1) begin
         bad++;
         $display("FAIL done_timeout: got hs_done=%b want 1", bus.hs_done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.pe_kick = 0; bus.pe_done = 0; bus.pe_addr_valid = 0;
      bus.pe_addr = '0; bus.pe_val = '0; bus.mem_wr_ready = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();
      total++; if (bus.pe_enable !== 1'b0) begin bad++; $display("FAIL rst_enable: got %b want 0", bus.pe_enable); end
      total++; if (bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.mem_wr_en); end
      total++; if (bus.mem_wr_addr !== 16'h0 || bus.mem_wr_data !== 8'h0) begin bad++; $display("FAIL rst_wr_bus: got %h/%h want 0/0", bus.mem_wr_addr, bus.mem_wr_data); end
      total++; if (bus.hs_busy !== 1'b0 || bus.hs_done !== 1'b0) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", bus.hs_busy, bus.hs_done); end
      total++; if (bus.hs_count !== 17'd0 || bus.hs_error !== 1'b0) begin bad++; $display("FAIL rst_count_err: got %0d/%b want 0/0", bus.hs_count, bus.hs_error); end
   endtask

   task automatic test_stream_ready();
      bus.mem_wr_ready = 1'b1;
      wr_log.delete();
      done_cnt = 0;
      kick();
      total++; if (bus.pe_enable !== 1'b1 || bus.hs_busy !== 1'b1) begin bad++; $display("FAIL kick_enable: got en=%b busy=%b want 1/1", bus.pe_enable, bus.hs_busy); end
      send_beats(0, 16, 1'b0);
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
      total++; if (bus.hs_done !== 1'b1) begin bad++; $display("FAIL s1_done_timing: got %b want 1", bus.hs_done); end
      tick();
      total++; if (bus.hs_done !== 1'b0 || bus.hs_busy !== 1'b0) begin bad++; $display("FAIL s1_idle: got done=%b busy=%b want 0/0", bus.hs_done, bus.hs_busy); end
      total++; if (bus.hs_count !== 17'd16) begin bad++; $display("FAIL s1_count: got %0d want 16", bus.hs_count); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL s1_done_pulses: got %0d want 1", done_cnt); end
      total++; if (wr_log.size() != 16) begin bad++; $display("FAIL s1_writes: got %0d want 16", wr_log.size()); end
      for (int i = 0; i < wr_log.size() && i < 16; i++) begin
         total++;
         if (wr_log[i].addr !== 16'(i) || wr_log[i].data !== 8'(i)) begin
            bad++;
            $display("FAIL s1_write%0d: got %h/%h want %h/%h", i, wr_log[i].addr, wr_log[i].data, 16'(i), 8'(i));
         end
      end
   endtask

   task automatic test_stall();
      bus.mem_wr_ready = 1'b0;
      wr_log.delete();
      kick();
      send_beats(0, 4, 1'b0);
      total++; if (bus.pe_enable !== 1'b0) begin bad++; $display("FAIL s2_full_enable: got %b want 0", bus.pe_enable); end
      repeat (3) tick();
      total++; if (bus.pe_enable !== 1'b0 || bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL s2_hold: got en=%b wr_en=%b want 0/1", bus.pe_enable, bus.mem_wr_en); end
      total++; if (bus.mem_wr_addr !== 16'h0 || bus.mem_wr_data !== 8'h0) begin bad++; $display("FAIL s2_head: got %h/%h want 0/0", bus.mem_wr_addr, bus.mem_wr_data); end
      bus.mem_wr_ready = 1'b1;
      send_beats(4, 12, 1'b0);
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
      wait_done();
      tick();
      total++; if (bus.hs_count !== 17'd16) begin bad++; $display("FAIL s2_count: got %0d want 16", bus.hs_count); end
      total++; if (wr_log.size() != 16) begin bad++; $display("FAIL s2_writes: got %0d want 16", wr_log.size()); end
      for (int i = 0; i < wr_log.size() && i < 16; i++) begin
         total++;
         if (wr_log[i].addr !== 16'(i) || wr_log[i].data !== 8'(i)) begin
            bad++;
            $display("FAIL s2_write%0d: got %h/%h want %h/%h", i, wr_log[i].addr, wr_log[i].data, 16'(i), 8'(i));
         end
      end
   endtask

   task automatic test_drain_toggle();
      bus.mem_wr_ready = 1'b0;
      wr_log.delete();
      done_cnt = 0;
      kick();
      send_beats(16'h40, 3, 1'b0);
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
      // Pops happen on k = 0, 2, 4; the third one ends the frame.
      for (int k = 0; k < 5; k++) begin
         bus.mem_wr_ready = (k % 2 == 0);
         tick();
         total++;
         if (bus.hs_done !== (k == 4) || bus.hs_busy !== 1'b1) begin
            bad++;
            $display("FAIL s3_step%0d: got done=%b busy=%b want %b/1", k, bus.hs_done, bus.hs_busy, (k == 4));
         end
         if (k < 4) begin
            total++;
            if (bus.mem_wr_en !== 1'b1 || bus.mem_wr_addr !== 16'(16'h40 + k / 2 + 1)) begin
               bad++;
               $display("FAIL s3_head%0d: got %b/%h want 1/%h", k, bus.mem_wr_en, bus.mem_wr_addr, 16'(16'h40 + k / 2 + 1));
            end
         end
      end
      bus.mem_wr_ready = 1'b0;
      tick();
      total++; if (bus.hs_done !== 1'b0 || bus.hs_busy !== 1'b0) begin bad++; $display("FAIL s3_idle: got done=%b busy=%b want 0/0", bus.hs_done, bus.hs_busy); end
      total++; if (done_cnt != 1 || wr_log.size() != 3) begin bad++; $display("FAIL s3_totals: got pulses=%0d writes=%0d want 1/3", done_cnt, wr_log.size()); end
   endtask

   task automatic test_errors();
      bus.mem_wr_ready = 1'b1;
      wr_log.delete();
      total++; if (bus.hs_error !== 1'b0) begin bad++; $display("FAIL s4_err_before: got %b want 0", bus.hs_error); end
      bus.pe_addr_valid = 1'b1;
      bus.pe_addr = 16'h0099;
      bus.pe_val  = 8'h99;
      tick();
      bus.pe_addr_valid = 1'b0;
      total++; if (bus.hs_error !== 1'b1 || bus.mem_wr_en !== 1'b0 || bus.hs_busy !== 1'b0) begin bad++; $display("FAIL s4_idle_beat: got err=%b wr_en=%b busy=%b want 1/0/0", bus.hs_error, bus.mem_wr_en, bus.hs_busy); end
      kick();
      send_beats(16'h70, 1, 1'b0);
      kick();
      total++; if (bus.hs_busy !== 1'b1 || bus.hs_count !== 17'd1) begin bad++; $display("FAIL s4_run_kick: got busy=%b count=%0d want 1/1", bus.hs_busy, bus.hs_count); end
      bus.pe_done = 1'b1;
      tick();
      bus.pe_done = 1'b0;
      total++; if (bus.hs_done !== 1'b1) begin bad++; $display("FAIL s4_done: got %b want 1", bus.hs_done); end
      tick();
      total++; if (bus.hs_error !== 1'b1) begin bad++; $display("FAIL s4_err_sticky: got %b want 1", bus.hs_error); end
      total++;
      if (wr_log.size() != 1 || wr_log[0].addr !== 16'h0070 || wr_log[0].data !== 8'h70) begin
         bad++;
         $display("FAIL s4_writes: got n=%0d first=%h want n=1 first=0070", wr_log.size(),
                  (wr_log.size() > 0) ? wr_log[0].addr : 16'hxxxx);
      end
   endtask

   task automatic test_reset_mid();
      bus.mem_wr_ready = 1'b0;
      kick();
      total++; if (bus.hs_error !== 1'b1) begin bad++; $display("FAIL s5_err_next_frame: got %b want 1", bus.hs_error); end
      send_beats(16'h30, 2, 1'b0);
      total++; if (bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL s5_buffered: got %b want 1", bus.mem_wr_en); end
      #2 reset = 1'b1;
      #1;
      total++; if (bus.mem_wr_en !== 1'b0 || bus.pe_enable !== 1'b0) begin bad++; $display("FAIL s5_async_en: got wr_en=%b en=%b want 0/0", bus.mem_wr_en, bus.pe_enable); end
      total++; if (bus.mem_wr_addr !== 16'h0 || bus.mem_wr_data !== 8'h0) begin bad++; $display("FAIL s5_async_bus: got %h/%h want 0/0", bus.mem_wr_addr, bus.mem_wr_data); end
      total++; if (bus.hs_busy !== 1'b0 || bus.hs_done !== 1'b0 || bus.hs_error !== 1'b0 || bus.hs_count !== 17'd0) begin bad++; $display("FAIL s5_async_hs: got busy=%b done=%b err=%b count=%0d want 0/0/0/0", bus.hs_busy, bus.hs_done, bus.hs_error, bus.hs_count); end
      tick();
      reset = 1'b0;
      wr_log.delete();
      bus.mem_wr_ready = 1'b1;
      kick();
      send_beats(16'h0123, 1, 1'b1);
      wait_done();
      total++; if (bus.hs_count !== 17'd1) begin bad++; $display("FAIL s5_count: got %0d want 1", bus.hs_count); end
      total++;
      if (wr_log.size() != 1 || wr_log[0].addr !== 16'h0123 || wr_log[0].data !== 8'h23) begin
         bad++;
         $display("FAIL s5_writes: got n=%0d want n=1 first=0123/23", wr_log.size());
      end
      tick();
   endtask

   task automatic test_beat_with_done();
      bus.mem_wr_ready = 1'b1;
      wr_log.delete();
      kick();
      send_beats(16'h0200, 1, 1'b1);
      total++; if (bus.mem_wr_en !== 1'b1 || bus.hs_done !== 1'b0 || bus.hs_count !== 17'd1) begin bad++; $display("FAIL s6_accept: got wr_en=%b done=%b count=%0d want 1/0/1", bus.mem_wr_en, bus.hs_done, bus.hs_count); end
      tick();
      total++; if (bus.hs_done !== 1'b1) begin bad++; $display("FAIL s6_done: got %b want 1", bus.hs_done); end
      total++;
      if (wr_log.size() != 1 || wr_log[0].addr !== 16'h0200 || wr_log[0].data !== 8'h00) begin
         bad++;
         $display("FAIL s6_writes: got n=%0d want n=1 first=0200/00", wr_log.size());
      end
      tick();
      total++; if (bus.hs_busy !== 1'b0) begin bad++; $display("FAIL s6_idle: got busy=%b want 0", bus.hs_busy); end
   endtask

   initial begin
      test_reset();
      test_stream_ready();
      test_stall();
      test_drain_toggle();
      test_errors();
      test_reset_mid();
      test_beat_with_done();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nabp_image_ram_writer.md
# nabp_image_ram_writer

Downstream stage of the NABP top level. It consumes the reconstructed-pixel stream that the processing-element domino chain and the image addresser produce (kick, address-valid, address, value, done). It buffers the pixels in a small FIFO and writes them to the image RAM write port over a valid/ready handshake. It throttles the stream through the enable it returns to NABP, and reports completion to the host only after every accepted pixel has been written.

## Interface
Parameters:
- ADDR_LEN, 16, image address width (equal to kImageAddressLength)
- DATA_LEN, 8, pixel width (equal to kCacheDataLength)
- FIFO_DEPTH, 4, buffer entries; power of two, at least 2

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pe_kick  in  1  one-cycle pulse: start of image output (from NABP ir_kick)
- pe_done  in  1  one-cycle pulse: last pixel issued (from NABP ir_done)
- pe_addr_valid  in  1  pixel beat present (from NABP ir_addr_valid)
- pe_addr  in  ADDR_LEN  pixel address
- pe_val  in  DATA_LEN  pixel value, aligned with pe_addr
- pe_enable  out  1  writer can accept a beat (to NABP ir_enable)
- mem_wr_en  out  1  write request valid
- mem_wr_addr  out  ADDR_LEN  write address
- mem_wr_data  out  DATA_LEN  write data
- mem_wr_ready  in  1  RAM accepts the request this cycle
- hs_busy  out  1  high outside IDLE
- hs_done  out  1  one-cycle completion pulse
- hs_count  out  ADDR_LEN+1  beats accepted in the current or last frame
- hs_error  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on pe_kick go to RUN and clear hs_count to 0. hs_error is not cleared.
- RUN: a beat is accepted when pe_addr_valid && pe_enable. The accepted {pe_addr, pe_val} is pushed to the FIFO and hs_count increments. On pe_done go to DRAIN; a beat valid in the same cycle is still accepted.
- DRAIN: no new beats are accepted. Go to DONE on the edge where the FIFO becomes empty, or immediately if it is already empty.
- DONE: lasts exactly one cycle with hs_done high, then returns to IDLE.
- pe_enable = (state == RUN) && (fifo_count < FIFO_DEPTH). It depends only on registered state, with no combinational path from any input.
- mem_wr_en = FIFO not empty. mem_wr_addr and mem_wr_data come from the FIFO head. The head pops when mem_wr_en && mem_wr_ready.
- Simultaneous push and pop: allowed whenever not full, and fifo_count is unchanged. When full, pe_enable is low, so no push occurs even if a pop happens that cycle.
- hs_count saturates at 2^(ADDR_LEN+1)-1.
- Each of the following sets hs_error; the offending event has no other effect:
  - pe_addr_valid with pe_enable low outside RUN
  - pe_kick outside IDLE
  - pe_done outside RUN
- hs_error clears only on reset.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an occupancy counter of width log2(FIFO_DEPTH)+1.

## Timing
- Reset values: state IDLE, FIFO empty, hs_count 0. All outputs are 0: pe_enable, mem_wr_en, mem_wr_addr, mem_wr_data, hs_busy, hs_done, hs_error.
- Reset mid-frame: takes effect immediately (asynchronous). Buffered pixels are discarded, and mem_wr_en drops in the same cycle.
- pe_enable rises the cycle after pe_kick is sampled.
- Latency from an accepted beat into an empty FIFO to mem_wr_en high: 1 cycle.
- Throughput: one beat per cycle when mem_wr_ready is held high.
- hs_done rises the cycle after the final pop, or 1 cycle after pe_done if the FIFO is already empty.
- hs_busy is high in RUN, DRAIN and DONE.
- mem_wr_addr and mem_wr_data hold stable while mem_wr_en is high and mem_wr_ready is low.

## Structure
- Package nabp_image_writer_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - default constants for ADDR_LEN, DATA_LEN and FIFO_DEPTH
  - the FIFO entry struct {addr, data}
- Sub-module nabp_sync_fifo: parameterised width and depth, registered storage, with push, pop, full, empty and count. The writer instantiates it with width ADDR_LEN+DATA_LEN.

## Test plan
- Kick, then 16 beats at addresses 0..15 with value = address, mem_wr_ready held 1, then pe_done -> 16 writes in order with matching data, hs_count = 16, one hs_done pulse 2 cycles after the last beat.
- Same stream with mem_wr_ready held 0 -> pe_enable falls after 4 accepted beats. Releasing ready -> all 16 writes complete with no loss or duplication, and mem_wr_addr and mem_wr_data are stable during each stall.
- pe_done arriving with 3 entries buffered and mem_wr_ready toggling 1/0 -> state stays DRAIN until the 3rd pop, then a single hs_done pulse.
- Beat presented while IDLE, then pe_kick issued in RUN -> neither write occurs, hs_error goes to 1 and stays 1 through the next frame until reset.
- Reset asserted with 2 entries buffered -> mem_wr_en goes to 0 immediately and all outputs take reset values. A subsequent kick and a 1-beat frame complete normally with hs_count = 1.
- A beat presented with pe_done in the same cycle, FIFO empty -> the beat is written and hs_count increments. hs_done follows 1 cycle after the write handshake.
